ram_burst_engine: RTL and testbench

RAM_BURST_ENGINE -- requirements
Module: ram_burst_engine

---
 rtl/ram_burst_engine.sv | 157 +++++++++++++++
 tb/tb_ram_burst_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_engine.sv
// ram_burst_engine
// Moves a burst of up to MAX_WORDS words between a flat word buffer and a
// single-port synchronous RAM. A request is taken from IDLE while start is
// high. The request is then either streamed out as RAM writes or gathered
// back as RAM reads. The block then waits in DONE until the requester
// drops start.
//
// Ports
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          request level, held until done is seen
//   write_en       1 = write burst, 0 = read burst (sampled at acceptance)
//   address        base word address (sampled at acceptance)
//   words          word count, 0..MAX_WORDS valid (sampled at acceptance)
//   wdata          write buffer, word 0 in the MSBs
//   rdata          read buffer, same packing as wdata
//   done           transfer complete (held while start stays high)
//   busy           transfer in progress
//   error          request rejected (word count above MAX_WORDS)
//   mem_addr       RAM address
//   mem_wdata      RAM write data
//   mem_we         RAM write enable
//   mem_rdata      RAM read data, one cycle after the address
module ram_burst_engine #(
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 16,
  parameter int ADDR_W    = 16
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             write_en,
  input  logic [ADDR_W-1:0]                address,
  input  logic [$clog2(MAX_WORDS+1)-1:0]   words,
  input  logic [WORD_W*MAX_WORDS-1:0]      wdata,
  output logic [WORD_W*MAX_WORDS-1:0]      rdata,
  output logic                             done,
  output logic                             busy,
  output logic                             error,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [WORD_W-1:0]                mem_wdata,
  output logic                             mem_we,
  input  logic [WORD_W-1:0]                mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic                             req_we;
  logic [CNT_W-1:0]                 req_words;
  logic [CNT_W-1:0]                 idx;
  logic                             err_q;
  logic [MAX_WORDS-1:0][WORD_W-1:0] wdata_words;
  logic [MAX_WORDS-1:0][WORD_W-1:0] wbuf;
  logic [MAX_WORDS-1:0][WORD_W-1:0] rbuf;
  logic                             req_bad;
  logic                             req_empty;
  logic                             last_idx;

  // Word i of the flat buffers lives in packed element MAX_WORDS-1-i.
  function automatic logic [IDX_W-1:0] word_slot(input logic [CNT_W-1:0] i);
    return IDX_W'(CNT_W'(MAX_WORDS - 1) - i);
  endfunction

  assign wdata_words = wdata;
  assign rdata       = rbuf;
  assign req_bad     = (words > CNT_W'(MAX_WORDS));
  assign req_empty   = (words == '0);
  assign last_idx    = (idx == req_words - CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (req_bad || req_empty) ? DONE : XFER;
      XFER: begin
        if (!start)        state_nxt = IDLE;
        else if (last_idx) state_nxt = req_we ? DONE : DRAIN;
      end
      DRAIN:   state_nxt = start ? DONE : IDLE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done  = (state == DONE);
    busy  = (state == XFER) || (state == DRAIN);
    error = (state == DONE) && err_q;
  end

  // The RAM-side signals are registered, but they are loaded one step ahead.
  // As a result, word i is presented in the same cycle that idx == i.
  // Read data for address i-1 arrives while idx == i. The last word is
  // picked up in DRAIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_we    <= 1'b0;
      req_words <= '0;
      wbuf      <= '0;
      idx       <= '0;
      err_q     <= 1'b0;
      rbuf      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req_we    <= write_en;
            req_words <= words;
            wbuf      <= wdata_words;
            err_q     <= req_bad;
            idx       <= '0;
            if (!req_bad && !req_empty) begin
              mem_addr <= address;
              if (write_en) begin
                mem_wdata <= wdata_words[MAX_WORDS-1];
                mem_we    <= 1'b1;
              end else begin
                rbuf <= '0;
              end
            end
          end
        end
        XFER: begin
          // A capture that falls due on an abort edge still lands.
          if (!req_we && idx != '0)
            rbuf[word_slot(idx - CNT_W'(1))] <= mem_rdata;
          if (start) begin
            idx <= idx + CNT_W'(1);
            if (!last_idx) begin
              mem_addr <= mem_addr + ADDR_W'(1);
              if (req_we) begin
                mem_wdata <= wbuf[word_slot(idx + CNT_W'(1))];
                mem_we    <= 1'b1;
              end
            end
          end
        end
        DRAIN: rbuf[word_slot(idx - CNT_W'(1))] <= mem_rdata;
        DONE:  if (!start) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_engine.sv
module tb_ram_burst_engine;

  logic         clock;
  logic         reset;
  logic         start;
  logic         write_en;
  logic [15:0]  address;
  logic [4:0]   words;
  logic [255:0] wdata;
  int           sel;

  logic         start_a, done_a, busy_a, error_a, mem_we_a;
  logic [255:0] rdata_a;
  logic [15:0]  mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic         start_b, done_b, busy_b, error_b, mem_we_b;
  logic [255:0] rdata_b;
  logic [9:0]   mem_addr_b;
  logic [31:0]  mem_wdata_b, mem_rdata_b;

  logic         done_m, busy_m, error_m, mem_we_m;
  logic [255:0] rdata_m;
  logic [15:0]  mem_addr_m;
  logic [31:0]  mem_wdata_m;

  typedef struct { int a; logic [31:0] d; } wr_t;
  wr_t wlog[$];

  typedef struct {
    int s; bit we; int addr; int n; int lat; bit err; int wbase; bit has_r; logic [255:0] rexp;
  } vec_t;

  logic [15:0]  ram_a    [65536];
  logic [31:0]  ram_b    [1024];
  logic [15:0]  shadow_a [65536];
  logic [31:0]  shadow_b [1024];
  logic [255:0] model_rd [2];

  int checks = 0;
  int errors = 0;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);

  ram_burst_engine dut_a (
    .clock(clock), .reset(reset), .start(start_a), .write_en(write_en),
    .address(address), .words(words), .wdata(wdata), .rdata(rdata_a),
    .done(done_a), .busy(busy_a), .error(error_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_rdata(mem_rdata_a)
  );

  ram_burst_engine #(.WORD_W(32), .MAX_WORDS(8), .ADDR_W(10)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .write_en(write_en),
    .address(address[9:0]), .words(words[3:0]), .wdata(wdata), .rdata(rdata_b),
    .done(done_b), .busy(busy_b), .error(error_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b)
  );

  always_comb begin
    if (sel == 0) begin
      done_m = done_a; busy_m = busy_a; error_m = error_a; mem_we_m = mem_we_a;
      rdata_m = rdata_a; mem_addr_m = mem_addr_a; mem_wdata_m = {16'h0, mem_wdata_a};
    end else begin
      done_m = done_b; busy_m = busy_b; error_m = error_b; mem_we_m = mem_we_b;
      rdata_m = rdata_b; mem_addr_m = {6'h0, mem_addr_b}; mem_wdata_m = mem_wdata_b;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pre(int s, int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return s != 0 ? (h ^ 32'h1234_5678) : {16'h0, h[31:16]};
  endfunction

  // Synchronous single-port RAMs: read data one cycle after the address.
  initial begin
    for (int i = 0; i < 65536; i++) ram_a[i] = 16'(pre(0, i));
    for (int i = 0; i < 1024; i++)  ram_b[i] = pre(1, i);
    forever begin
      @(posedge clock);
      mem_rdata_a <= ram_a[mem_addr_a];
      mem_rdata_b <= ram_b[mem_addr_b];
      if (mem_we_a) begin
        ram_a[mem_addr_a] = mem_wdata_a;
        wlog.push_back('{int'(mem_addr_a), {16'h0, mem_wdata_a}});
      end
      if (mem_we_b) begin
        ram_b[mem_addr_b] = mem_wdata_b;
        wlog.push_back('{int'(mem_addr_b), mem_wdata_b});
      end
    end
  end

  function automatic logic [31:0] shadow_rd(int s, int a);
    return s != 0 ? shadow_b[a] : {16'h0, shadow_a[a]};
  endfunction

  task automatic shadow_wr(input int s, input int a, input logic [31:0] d);
    if (s != 0) shadow_b[a] = d;
    else        shadow_a[a] = d[15:0];
  endtask

  function automatic logic [31:0] word_of(int s, logic [255:0] wd, int i);
    logic [255:0] t;
    t = wd >> ((s != 0 ? 32 : 16) * ((s != 0 ? 8 : 16) - 1 - i));
    return s != 0 ? t[31:0] : {16'h0, t[15:0]};
  endfunction

  function automatic logic [255:0] place(int s, logic [31:0] w, int i);
    logic [255:0] t;
    t = (s != 0) ? {224'h0, w} : {240'h0, w[15:0]};
    return t << ((s != 0 ? 32 : 16) * ((s != 0 ? 8 : 16) - 1 - i));
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h, expected %0h", nm, sel, act, exp);
    end
  endtask

  // One complete request/handshake, checked against the burst rules.
  task automatic run_xfer(input int s, input bit we, input int addr, input int n,
                          input logic [255:0] wd, input int exp_lat, input bit exp_err);
    int mw, am, cnt, bcnt;
    bit ok;
    mw = (s != 0) ? 8 : 16;
    am = (s != 0) ? 'h3FF : 'hFFFF;
    ok = (n > 0) && (n <= mw);
    if (ok && !we) begin
      model_rd[s] = '0;
      for (int i = 0; i < n; i++) model_rd[s] |= place(s, shadow_rd(s, (addr + i) & am), i);
    end
    wlog.delete();
    sel = s; write_en = we; address = 16'(addr); words = 5'(n); wdata = wd; start = 1'b1;
    @(posedge clock); #1;
    wdata = rnd256();
    cnt = 0; bcnt = 0;
    while (!done_m && cnt < 40) begin
      if (busy_m) bcnt++;
      @(posedge clock); #1;
      cnt++;
    end
    chk("done_latency", 256'(cnt + 1), 256'(exp_lat));
    chk("error_flag", 256'(error_m), 256'(exp_err));
    chk("busy_cycles", 256'(bcnt), 256'(!ok ? 0 : (we ? n : n + 1)));
    chk("write_count", 256'(wlog.size()), 256'((ok && we) ? n : 0));
    for (int i = 0; i < wlog.size() && i < n; i++) begin
      chk("write_addr", 256'(wlog[i].a), 256'((addr + i) & am));
      chk("write_data", 256'(wlog[i].d), 256'(word_of(s, wd, i)));
    end
    if (ok && we)
      for (int i = 0; i < n; i++) shadow_wr(s, (addr + i) & am, word_of(s, wd, i));
    chk("rdata", rdata_m, model_rd[s]);
    @(posedge clock); #1;
    chk("done_hold", 256'({done_m, error_m}), 256'({1'b1, exp_err}));
    start = 1'b0;
    @(posedge clock); #1;
    chk("done_clear", 256'({done_m, error_m, busy_m, mem_we_m}), 256'(0));
  endtask

  // 8-word write with start dropped after two write cycles.
  task automatic abort_seq(input int s);
    logic [255:0] wd;
    wd = rnd256();
    wlog.delete();
    sel = s; write_en = 1'b1; address = 16'h0100; words = 5'd8; wdata = wd; start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    chk("abort_idle", 256'({busy_m, done_m, mem_we_m}), 256'(0));
    repeat (3) begin
      @(posedge clock); #1;
      chk("abort_no_done", 256'(done_m), 256'(0));
    end
    chk("abort_writes", 256'(wlog.size()), 256'(2));
    for (int i = 0; i < wlog.size() && i < 2; i++) begin
      chk("abort_addr", 256'(wlog[i].a), 256'('h100 + i));
      chk("abort_data", 256'(wlog[i].d), 256'(word_of(s, wd, i)));
    end
    for (int i = 0; i < 2; i++) shadow_wr(s, 'h100 + i, word_of(s, wd, i));
  endtask

  // Reset in the middle of a read burst, then a fresh one-word read.
  task automatic reset_seq(input int s);
    sel = s; write_en = 1'b0; address = 16'h0010; words = 5'd4; wdata = '0; start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_ctrl", 256'({done_m, busy_m, error_m, mem_we_m, mem_addr_m, mem_wdata_m}), 256'(0));
    chk("reset_rdata", rdata_m, 256'(0));
    reset = 1'b0; start = 1'b0;
    model_rd[0] = '0; model_rd[1] = '0;
    @(posedge clock); #1;
    run_xfer(s, 1'b0, 'h12, 1, '0, 3, 1'b0);
  endtask

  initial begin
    vec_t tbl[15];
    logic [255:0] wd;
    int mw, n, addr;
    bit we;

    tbl[0]  = '{0, 1, 'h0010, 4,  5, 0, 'hA000, 0, '0};
    tbl[1]  = '{0, 0, 'h0010, 4,  6, 0, 0, 1, {64'hA000_A001_A002_A003, 192'h0}};
    tbl[2]  = '{0, 1, 'hFFFE, 3,  4, 0, 'hC000, 0, '0};
    tbl[3]  = '{0, 0, 'hFFFE, 3,  5, 0, 0, 1, {48'hC000_C001_C002, 208'h0}};
    tbl[4]  = '{0, 1, 'h0020, 0,  1, 0, 'hB000, 0, '0};
    tbl[5]  = '{0, 1, 'h0020, 17, 1, 1, 'hB000, 0, '0};
    tbl[6]  = '{0, 0, 'h0020, 17, 1, 1, 0, 1, {48'hC000_C001_C002, 208'h0}};
    tbl[7]  = '{0, 1, 'h0040, 16, 17, 0, 'hD000, 0, '0};
    tbl[8]  = '{1, 1, 'h010, 4,  5, 0, 'hA000, 0, '0};
    tbl[9]  = '{1, 0, 'h010, 4,  6, 0, 0, 1, {128'h0000A000_0000A001_0000A002_0000A003, 128'h0}};
    tbl[10] = '{1, 1, 'h3FE, 3,  4, 0, 'hC000, 0, '0};
    tbl[11] = '{1, 0, 'h3FE, 3,  5, 0, 0, 1, {96'h0000C000_0000C001_0000C002, 160'h0}};
    tbl[12] = '{1, 1, 'h020, 0,  1, 0, 'hB000, 0, '0};
    tbl[13] = '{1, 1, 'h020, 9,  1, 1, 'hB000, 0, '0};
    tbl[14] = '{1, 0, 'h040, 8,  10, 0, 0, 0, '0};

    for (int i = 0; i < 65536; i++) shadow_a[i] = 16'(pre(0, i));
    for (int i = 0; i < 1024; i++)  shadow_b[i] = pre(1, i);
    model_rd[0] = '0; model_rd[1] = '0;

    sel = 0; start = 1'b0; write_en = 1'b0; address = '0; words = '0; wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_a", 256'({done_a, busy_a, error_a, mem_we_a, mem_addr_a, mem_wdata_a}), 256'(0));
    chk("reset_a_rdata", rdata_a, 256'(0));
    chk("reset_b", 256'({done_b, busy_b, error_b, mem_we_b, mem_addr_b, mem_wdata_b}), 256'(0));
    chk("reset_b_rdata", rdata_b, 256'(0));

    for (int r = 0; r < 15; r++) begin
      mw = (tbl[r].s != 0) ? 8 : 16;
      wd = '0;
      for (int i = 0; i < mw; i++) wd |= place(tbl[r].s, 32'(tbl[r].wbase + i), i);
      run_xfer(tbl[r].s, tbl[r].we, tbl[r].addr, tbl[r].n, wd, tbl[r].lat, tbl[r].err);
      if (tbl[r].has_r) chk("rdata_directed", rdata_m, tbl[r].rexp);
    end

    for (int s = 0; s < 2; s++) abort_seq(s);
    for (int s = 0; s < 2; s++) reset_seq(s);

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 12; k++) begin
        mw   = (s != 0) ? 8 : 16;
        n    = $urandom_range(0, mw + 1);
        we   = 1'($urandom_range(0, 1));
        addr = $urandom_range(0, (s != 0) ? 1023 : 65535);
        wd   = rnd256();
        run_xfer(s, we, addr, n, wd, (n == 0 || n > mw) ? 1 : (we ? n + 1 : n + 2), n > mw);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
